// File: rtl/shiftreg_sequencer.sv
// ============================================================================
// Module      : shiftreg_sequencer
// Description : Upstream control stage for a parallel-load shift register.
//               Accepts a word over a valid/ready handshake, loads it into
//               the downstream register, then issues DATASIZE shift commands
//               while steering ser_i into the vacated end. Emits a one-cycle
//               done pulse after the last shift.
//               Optional feature macro: SHREG_SEQ_PAUSE_EN (adds pause_i,
//               which freezes shifting while high).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_sequencer #(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATASIZE-1:0] data_i,
    input  logic                dir_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                ser_i,
`ifdef SHREG_SEQ_PAUSE_EN
    input  logic                pause_i,
`endif
    output logic [1:0]          mode_o,
    output logic [DATASIZE-1:0] load_value_o,
    output logic                ser_in_msb_o,
    output logic                ser_in_lsb_o,
    output logic                busy_o,
    output logic                done_o
);

    // Counter only has to reach DATASIZE-1, so it never needs to wrap.
    localparam int                 c_CNT_W    = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATASIZE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Downstream shift register mode encoding.
    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_LEFT  = 2'b01;
    localparam logic [1:0] c_MODE_RIGHT = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DATASIZE-1:0]  r_word;
    logic                 r_dir;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_pause;
    logic                 w_accept;
    logic                 w_shift_active;

`ifdef SHREG_SEQ_PAUSE_EN
    assign w_pause = pause_i;
`else
    assign w_pause = 1'b0;
`endif

    // ready_o is high exactly in IDLE, so the handshake reduces to this.
    assign w_accept       = (r_state == S_IDLE) && valid_i;
    // A real shift happens only in SHIFT while not paused.
    assign w_shift_active = (r_state == S_SHIFT) && !w_pause;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word/direction capture and shift counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_word <= '0;
            r_dir  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_word <= data_i;
                r_dir  <= dir_i;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if (w_shift_active && (r_cnt != c_CNT_LAST)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state and output decode from registered state.
    always_comb begin
        w_next_state = r_state;
        ready_o      = 1'b0;
        mode_o       = c_MODE_HOLD;
        ser_in_msb_o = 1'b0;
        ser_in_lsb_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                busy_o       = 1'b1;
                mode_o       = c_MODE_LOAD;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                busy_o = 1'b1;
                if (!w_pause) begin
                    if (r_dir) begin
                        mode_o       = c_MODE_RIGHT;
                        ser_in_msb_o = ser_i;
                    end else begin
                        mode_o       = c_MODE_LEFT;
                        ser_in_lsb_o = ser_i;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The latched word is presented continuously; the downstream register
    // only consumes it when mode_o is LOAD.
    assign load_value_o = r_word;

endmodule

`default_nettype wire
